// File: rtl/d_to_sr_pkg.sv
// Shared definitions for the D-storage SR flip-flop bank:
// conflict-policy encodings and the error-report FSM state type.
package d_to_sr_pkg;

    localparam int POLICY_HOLD = 0;
    localparam int POLICY_SET  = 1;
    localparam int POLICY_RST  = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        REPORT = 1'b1
    } state_t;

endpackage

// File: rtl/sr_cell.sv
// Single SR cell: set/reset next-state logic in front of a D flip-flop.
// POLICY selects what S=R=1 does (hold, set-dominant, reset-dominant).
module sr_cell
    import d_to_sr_pkg::*;
#(
    parameter int POLICY = POLICY_HOLD
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic s,
    input  logic r,
    output logic q
);

    logic q_reg;
    logic q_next;

    // Translate set/reset into the D input, resolving S=R=1 by policy.
    always_comb begin
        q_next = q_reg;
        if (en) begin
            unique case ({s, r})
                2'b10:   q_next = 1'b1;
                2'b01:   q_next = 1'b0;
                2'b11: begin
                    if (POLICY == POLICY_SET)
                        q_next = 1'b1;
                    else if (POLICY == POLICY_RST)
                        q_next = 1'b0;
                    else
                        q_next = q_reg;
                end
                default: q_next = q_reg;
            endcase
        end
    end

    // D flip-flop storage.
    always_ff @(posedge clk) begin
        if (rst)
            q_reg <= 1'b0;
        else
            q_reg <= q_next;
    end

    assign q = q_reg;

endmodule

// File: rtl/d_to_sr_ff_bank.sv
// WIDTH-bit bank of SR cells with a valid/ready channel that reports the
// lowest index of any bit driven with S=R=1 while enabled, plus a sticky
// overflow flag for reports dropped while one is still pending.
// Optional macro D_TO_SR_ERR_CNT_EN adds a saturating conflict-cycle
// counter on port err_cnt.
module d_to_sr_ff_bank
    import d_to_sr_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int CONFLICT_POLICY = POLICY_HOLD,
    parameter int CNT_W           = 8,
    localparam int IDX_W          = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             err_valid,
    output logic [IDX_W-1:0] err_idx,
    input  logic             err_ready,
    output logic             err_ovf,
    input  logic             err_clr
`ifdef D_TO_SR_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    logic [WIDTH-1:0] conflict;
    logic             conflict_any;
    logic [IDX_W-1:0] low_idx;

    state_t           state_reg;
    state_t           state_next;
    logic [IDX_W-1:0] err_idx_reg;
    logic [IDX_W-1:0] err_idx_next;
    logic             err_ovf_reg;
    logic             err_ovf_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            sr_cell #(
                .POLICY(CONFLICT_POLICY)
            ) u_cell (
                .clk(clk),
                .rst(rst),
                .en (en),
                .s  (s[gi]),
                .r  (r[gi]),
                .q  (q[gi])
            );
        end
    endgenerate

    assign qn           = ~q;
    assign conflict     = s & r & {WIDTH{en}};
    assign conflict_any = |conflict;

    // Lowest-index priority encoder: scan high to low so the lowest hit wins.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (conflict[i])
                low_idx = IDX_W'(i);
        end
    end

    // Report FSM next state; a dropped report outranks err_clr on err_ovf.
    always_comb begin
        state_next   = state_reg;
        err_idx_next = err_idx_reg;
        err_ovf_next = err_ovf_reg;
        if (err_clr)
            err_ovf_next = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (conflict_any) begin
                    state_next   = REPORT;
                    err_idx_next = low_idx;
                end
            end
            REPORT: begin
                if (err_ready) begin
                    if (conflict_any)
                        err_idx_next = low_idx;
                    else
                        state_next = IDLE;
                end else if (conflict_any) begin
                    err_ovf_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Report FSM state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            err_idx_reg <= '0;
            err_ovf_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            err_idx_reg <= err_idx_next;
            err_ovf_reg <= err_ovf_next;
        end
    end

    assign err_valid = (state_reg == REPORT);
    assign err_idx   = err_idx_reg;
    assign err_ovf   = err_ovf_reg;

`ifdef D_TO_SR_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_reg;
    logic [CNT_W-1:0] err_cnt_next;

    // Saturating count of conflict cycles; clear restarts from this cycle.
    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (err_clr)
            err_cnt_next = conflict_any ? CNT_W'(1) : '0;
        else if (conflict_any && (err_cnt_reg != {CNT_W{1'b1}}))
            err_cnt_next = err_cnt_reg + CNT_W'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst)
            err_cnt_reg <= '0;
        else
            err_cnt_reg <= err_cnt_next;
    end

    assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_d_to_sr_ff_bank.sv
// Directed self-checking bench for d_to_sr_ff_bank (WIDTH=4). Three copies
// share the stimulus, one per conflict policy. Counter checks compile only
// with D_TO_SR_ERR_CNT_EN (counter width 2).
module tb_d_to_sr_ff_bank;

    logic       clk = 1'b0;
    logic       rst, en, err_ready, err_clr;
    logic [3:0] s, r;

    logic [3:0] q_h, qn_h, q_s, qn_s, q_r, qn_r;
    logic       ev_h, ev_s, ev_r, eo_h, eo_s, eo_r;
    logic [1:0] ei_h, ei_s, ei_r;
`ifdef D_TO_SR_ERR_CNT_EN
    logic [1:0] cnt_h, cnt_s, cnt_r;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    d_to_sr_ff_bank #(.WIDTH(4), .CONFLICT_POLICY(0), .CNT_W(2)) dut_hold (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .q(q_h), .qn(qn_h),
        .err_valid(ev_h), .err_idx(ei_h), .err_ready(err_ready),
        .err_ovf(eo_h), .err_clr(err_clr)
`ifdef D_TO_SR_ERR_CNT_EN
        , .err_cnt(cnt_h)
`endif
    );

    d_to_sr_ff_bank #(.WIDTH(4), .CONFLICT_POLICY(1), .CNT_W(2)) dut_set (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .q(q_s), .qn(qn_s),
        .err_valid(ev_s), .err_idx(ei_s), .err_ready(err_ready),
        .err_ovf(eo_s), .err_clr(err_clr)
`ifdef D_TO_SR_ERR_CNT_EN
        , .err_cnt(cnt_s)
`endif
    );

    d_to_sr_ff_bank #(.WIDTH(4), .CONFLICT_POLICY(2), .CNT_W(2)) dut_rst (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .q(q_r), .qn(qn_r),
        .err_valid(ev_r), .err_idx(ei_r), .err_ready(err_ready),
        .err_ovf(eo_r), .err_clr(err_clr)
`ifdef D_TO_SR_ERR_CNT_EN
        , .err_cnt(cnt_r)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock transaction: apply current inputs, sample 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t rst=%b en=%b s=%b r=%b rdy=%b clr=%b | q=%b v=%b idx=%0d ovf=%b",
                 $time, rst, en, s, r, err_ready, err_clr, q_h, ev_h, ei_h, eo_h);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; s = 4'b0; r = 4'b0; err_ready = 1'b0; err_clr = 1'b0;
        #2;
        tick();
        chk("reset_q",     32'(q_h),  32'h0);
        chk("reset_qn",    32'(qn_h), 32'hf);
        chk("reset_valid", 32'(ev_h), 32'h0);
        chk("reset_idx",   32'(ei_h), 32'h0);
        chk("reset_ovf",   32'(eo_h), 32'h0);
`ifdef D_TO_SR_ERR_CNT_EN
        chk("reset_cnt",   32'(cnt_h), 32'h0);
`endif

        // Basic set then reset
        rst = 1'b0; en = 1'b1; s = 4'b0101; r = 4'b0000;
        tick();
        chk("set_q",  32'(q_h),  32'h5);
        chk("set_qn", 32'(qn_h), 32'ha);
        s = 4'b0000; r = 4'b0001;
        tick();
        chk("clr_q", 32'(q_h), 32'h4);

        // Enable gating: no update, no conflict
        en = 1'b0; s = 4'b1111; r = 4'b1111;
        tick();
        chk("gate_q",     32'(q_h),  32'h4);
        chk("gate_valid", 32'(ev_h), 32'h0);

        // Clear all, then conflict on bit 1 under each policy
        en = 1'b1; s = 4'b0000; r = 4'b1111;
        tick();
        chk("zero_q", 32'(q_h), 32'h0);
        s = 4'b0010; r = 4'b0010;
        tick();
        chk("pol_hold_q", 32'(q_h), 32'h0);
        chk("pol_set_q",  32'(q_s), 32'h2);
        chk("pol_set_qn", 32'(qn_s), 32'hd);
        chk("pol_rst_q",  32'(q_r), 32'h0);
        chk("pol_valid_h", 32'(ev_h), 32'h1);
        chk("pol_valid_s", 32'(ev_s), 32'h1);
        chk("pol_valid_r", 32'(ev_r), 32'h1);
        chk("pol_idx_h", 32'(ei_h), 32'h1);
        chk("pol_idx_s", 32'(ei_s), 32'h1);
        chk("pol_idx_r", 32'(ei_r), 32'h1);

        // Handshake with no conflict returns to idle
        s = 4'b0000; r = 4'b0000; err_ready = 1'b1;
        tick();
        chk("ack_valid", 32'(ev_h), 32'h0);

        // Multi-bit conflict 1100 -> idx 2, held while not ready
        err_ready = 1'b0; s = 4'b1100; r = 4'b1100;
        tick();
        chk("multi_valid", 32'(ev_h), 32'h1);
        chk("multi_idx",   32'(ei_h), 32'h2);
        s = 4'b0000; r = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_valid", 32'(ev_h), 32'h1);
            chk("hold_idx",   32'(ei_h), 32'h2);
        end
        err_ready = 1'b1;
        tick();
        chk("hold_ack_valid", 32'(ev_h), 32'h0);

        // Back-to-back: report idx 0, then handshake with conflict on bit 3
        err_ready = 1'b0; s = 4'b0001; r = 4'b0001;
        tick();
        chk("b2b_first_idx", 32'(ei_h), 32'h0);
        err_ready = 1'b1; s = 4'b1000; r = 4'b1000;
        tick();
        chk("b2b_valid", 32'(ev_h), 32'h1);
        chk("b2b_idx",   32'(ei_h), 32'h3);
        chk("b2b_ovf",   32'(eo_h), 32'h0);

        // Dropped conflict sets overflow, index unchanged
        err_ready = 1'b0; s = 4'b0100; r = 4'b0100;
        tick();
        chk("drop_ovf",   32'(eo_h), 32'h1);
        chk("drop_idx",   32'(ei_h), 32'h3);
        chk("drop_valid", 32'(ev_h), 32'h1);

        // err_clr clears overflow, FSM untouched
        s = 4'b0000; r = 4'b0000; err_clr = 1'b1;
        tick();
        chk("eclr_ovf",   32'(eo_h), 32'h0);
        chk("eclr_valid", 32'(ev_h), 32'h1);

        // err_clr together with a drop: set wins
        s = 4'b0010; r = 4'b0010;
        tick();
        chk("eclr_drop_ovf", 32'(eo_h), 32'h1);
        chk("eclr_drop_idx", 32'(ei_h), 32'h3);
        s = 4'b0000; r = 4'b0000;
        tick();
        chk("eclr_again_ovf", 32'(eo_h), 32'h0);
        err_clr = 1'b0;

`ifdef D_TO_SR_ERR_CNT_EN
        // Saturating counter, width 2
        rst = 1'b1;
        tick();
        chk("cnt_rst", 32'(cnt_h), 32'h0);
        rst = 1'b0; s = 4'b0011; r = 4'b0011;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("cnt_sat", 32'(cnt_h), (k < 3) ? 32'(k) : 32'h3);
        end
        err_clr = 1'b1;
        tick();
        chk("cnt_clr_conflict", 32'(cnt_h), 32'h1);
        err_clr = 1'b0; s = 4'b0000; r = 4'b0000;
`endif

        // Reset in the middle of a report
        err_ready = 1'b0; s = 4'b0110; r = 4'b0100;
        tick();
        chk("pre_rst_valid", 32'(ev_h), 32'h1);
        chk("pre_rst_q_h",   32'(q_h),  32'h2);
        s = 4'b0000; r = 4'b0000; rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(ev_h), 32'h0);
        chk("mid_rst_q",     32'(q_h),  32'h0);
        chk("mid_rst_q_set", 32'(q_s),  32'h0);
        chk("mid_rst_ovf",   32'(eo_h), 32'h0);
`ifdef D_TO_SR_ERR_CNT_EN
        chk("mid_rst_cnt",   32'(cnt_h), 32'h0);
`endif
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
